// File: rtl/stage_mem_sram_pkg.sv
// Shared types and constants for the MEM stage and its SRAM controller.
//   state_e       : controller FSM states
//   BASE_ADDR_DEF : default data-memory base address
//   DATA_W        : pipeline word width
//   SRAM_DQ_W     : external SRAM data bus width
package stage_mem_sram_pkg;

  localparam int          DATA_W        = 32;
  localparam int          SRAM_DQ_W     = 16;
  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/stage_mem_sram_sram_controller.sv
// 32-bit load/store engine for a 16-bit asynchronous SRAM. Each word is
// moved as two half-word accesses (low half first), each held stable for
// ACCESS_CYCLES clocks. All SRAM pins and val_mem are registered.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   rd_req, wr_req    : access request (read wins when both are set)
//   addr, wdata       : byte address and store data
//   state             : current FSM state (used for the freeze output)
//   val_mem           : last completed load word
//   sram_*            : SRAM address, DQ in/out/enable, active-low WE/OE
module sram_controller
  import stage_mem_sram_pkg::*;
#(
  parameter logic [DATA_W-1:0] BASE_ADDR     = BASE_ADDR_DEF,
  parameter int                SRAM_ADDR_W   = 18,
  parameter int                ACCESS_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_req,
  input  logic                   wr_req,
  input  logic [DATA_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wdata,
  output state_e                 state,
  output logic [DATA_W-1:0]      val_mem,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DQ_W-1:0]   sram_dq_out,
  input  logic [SRAM_DQ_W-1:0]   sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n,
  output logic                   sram_oe_n
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  logic [CNT_W-1:0]       cnt;
  logic                   is_rd;
  logic [SRAM_DQ_W-1:0]   low_buf;
  logic [DATA_W-1:0]      off;
  logic [SRAM_ADDR_W-2:0] word_idx;
  logic                   last;
  logic                   unused_off;

  // Offset wraps modulo 2^32; byte-lane bits and bits above the SRAM range drop.
  assign off        = addr - BASE_ADDR;
  assign word_idx   = off[SRAM_ADDR_W:2];
  assign unused_off = ^{off[DATA_W-1:SRAM_ADDR_W+1], off[1:0]};
  assign last       = (cnt == CNT_W'(ACCESS_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      is_rd       <= 1'b0;
      low_buf     <= '0;
      val_mem     <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_req | wr_req) begin
            state      <= ST_LOW;
            cnt        <= '0;
            is_rd      <= rd_req;
            sram_addr  <= {word_idx, 1'b0};
            // Read suppresses the write when both requests are set.
            sram_we_n  <= rd_req;
            sram_oe_n  <= ~rd_req;
            sram_dq_oe <= ~rd_req;
            if (!rd_req) sram_dq_out <= wdata[15:0];
          end
        end
        ST_LOW: begin
          if (last) begin
            cnt       <= '0;
            state     <= ST_HIGH;
            sram_addr <= {sram_addr[SRAM_ADDR_W-1:1], 1'b1};
            if (is_rd) low_buf     <= sram_dq_in;
            else       sram_dq_out <= wdata[31:16];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HIGH: begin
          if (last) begin
            cnt        <= '0;
            state      <= ST_DONE;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (is_rd) val_mem <= {sram_dq_in, low_buf};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;  // ST_DONE: pipeline advances this cycle
      endcase
    end
  end

endmodule

// File: rtl/stage_mem_sram.sv
// MEM stage: wraps the SRAM controller, forwards EX fields to MEM/WB and
// raises freeze from the request cycle until the access reaches DONE.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   wbEnIn/memREnIn/memWEnIn/aluRes/exeValRm/dest : EX results
//   wbEnOut/memREnOut/aluResOut/destOut          : combinational pass-through
//   valMem                          : registered load data
//   freeze                          : pipeline stall request
//   sram*                           : external 16-bit async SRAM pins
module stage_mem_sram
  import stage_mem_sram_pkg::*;
#(
  parameter logic [DATA_W-1:0] BASE_ADDR     = BASE_ADDR_DEF,
  parameter int                SRAM_ADDR_W   = 18,
  parameter int                ACCESS_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wbEnIn,
  input  logic                   memREnIn,
  input  logic                   memWEnIn,
  input  logic [DATA_W-1:0]      aluRes,
  input  logic [DATA_W-1:0]      exeValRm,
  input  logic [3:0]             dest,
  output logic                   wbEnOut,
  output logic                   memREnOut,
  output logic [DATA_W-1:0]      aluResOut,
  output logic [3:0]             destOut,
  output logic [DATA_W-1:0]      valMem,
  output logic                   freeze,
  output logic [SRAM_ADDR_W-1:0] sramAddr,
  output logic [SRAM_DQ_W-1:0]   sramDqOut,
  input  logic [SRAM_DQ_W-1:0]   sramDqIn,
  output logic                   sramDqOe,
  output logic                   sramWeN,
  output logic                   sramOeN
);

  state_e state;

  sram_controller #(
    .BASE_ADDR    (BASE_ADDR),
    .SRAM_ADDR_W  (SRAM_ADDR_W),
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .rd_req     (memREnIn),
    .wr_req     (memWEnIn),
    .addr       (aluRes),
    .wdata      (exeValRm),
    .state      (state),
    .val_mem    (valMem),
    .sram_addr  (sramAddr),
    .sram_dq_out(sramDqOut),
    .sram_dq_in (sramDqIn),
    .sram_dq_oe (sramDqOe),
    .sram_we_n  (sramWeN),
    .sram_oe_n  (sramOeN)
  );

  assign wbEnOut   = wbEnIn;
  assign memREnOut = memREnIn;
  assign aluResOut = aluRes;
  assign destOut   = dest;

  // Dropping freeze in DONE lets the pipeline load the next instruction.
  assign freeze = ~rst & (memREnIn | memWEnIn) & (state != ST_DONE);

endmodule

// File: tb/tb_stage_mem_sram.sv
module tb_stage_mem_sram;

  logic        clk = 1'b0;
  logic        rst, pre;
  logic        wb_en, mem_r, mem_w;
  logic [31:0] alu, rm;
  logic [3:0]  dst;
  logic        wb_o, mem_r_o, frz;
  logic [31:0] alu_o, val;
  logic [3:0]  dst_o;
  logic [17:0] s_addr;
  logic [15:0] s_dq_out, s_dq_in;
  logic        s_dq_oe, s_we_n, s_oe_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stage_mem_sram dut (
    .clk(clk), .rst(rst), .wbEnIn(wb_en), .memREnIn(mem_r), .memWEnIn(mem_w),
    .aluRes(alu), .exeValRm(rm), .dest(dst),
    .wbEnOut(wb_o), .memREnOut(mem_r_o), .aluResOut(alu_o), .destOut(dst_o),
    .valMem(val), .freeze(frz), .sramAddr(s_addr), .sramDqOut(s_dq_out),
    .sramDqIn(s_dq_in), .sramDqOe(s_dq_oe), .sramWeN(s_we_n), .sramOeN(s_oe_n)
  );

  // 64-half-word SRAM model, prefilled with 0x1000+index.
  logic [15:0] mem [0:63];
  logic        unused_tb;
  assign s_dq_in   = mem[s_addr[5:0]];
  assign unused_tb = ^s_addr[17:6];

  always @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'(16'h1000 + i);
    end else if (!s_we_n && s_dq_oe) begin
      mem[s_addr[5:0]] <= s_dq_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one memory instruction starting in an IDLE cycle; ends in the
  // following IDLE cycle. ha = expected half-word address of the low half.
  task automatic mem_op(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [17:0] ha,
                        input logic [31:0] vm);
    bit wrt;
    wrt   = wr & ~rd;
    mem_r = rd; mem_w = wr; alu = a; rm = d;
    #1;
    chk("freeze_req", 32'(frz), 32'd1);
    for (int c = 0; c < 4; c++) begin
      tick;
      chk("freeze_acc", 32'(frz), 32'd1);
      chk("addr",  32'(s_addr), 32'(ha + ((c >= 2) ? 18'd1 : 18'd0)));
      chk("we_n",  32'(s_we_n), 32'(!wrt));
      chk("oe_n",  32'(s_oe_n), 32'(wrt));
      chk("dq_oe", 32'(s_dq_oe), 32'(wrt));
      if (wrt) chk("dq_out", 32'(s_dq_out), 32'((c < 2) ? d[15:0] : d[31:16]));
    end
    tick;
    chk("freeze_done", 32'(frz), 32'd0);
    chk("we_n_done", 32'(s_we_n), 32'd1);
    chk("oe_n_done", 32'(s_oe_n), 32'd1);
    chk("val_mem", val, vm);
    tick;
  endtask

  initial begin
    rst = 1'b1; pre = 1'b1; wb_en = 1'b0; mem_r = 1'b1; mem_w = 1'b0;
    alu = 32'd1024; rm = '0; dst = '0;
    tick;
    pre = 1'b0;
    tick;
    // Reset with a pending load held on the inputs.
    chk("rst_freeze", 32'(frz), 32'd0);
    chk("rst_we_n",   32'(s_we_n), 32'd1);
    chk("rst_oe_n",   32'(s_oe_n), 32'd1);
    chk("rst_dq_oe",  32'(s_dq_oe), 32'd0);
    chk("rst_val",    val, 32'd0);
    rst = 1'b0;
    mem_op(1, 0, 32'd1024, 32'd0, 18'd0, 32'h1001_1000);

    // Store then load the same word.
    mem_op(0, 1, 32'd1032, 32'hDEAD_BEEF, 18'd4, 32'h1001_1000);
    mem_op(1, 0, 32'd1032, 32'd0,         18'd4, 32'hDEAD_BEEF);

    // Back-to-back load and store, then read the stored word back.
    mem_op(1, 0, 32'd1024, 32'd0,         18'd0, 32'h1001_1000);
    mem_op(0, 1, 32'd1028, 32'h1357_2468, 18'd2, 32'h1001_1000);
    mem_op(1, 0, 32'd1028, 32'd0,         18'd2, 32'h1357_2468);

    // Both enables: read wins, the word is left untouched.
    mem_op(1, 1, 32'd1032, 32'hFFFF_FFFF, 18'd4, 32'hDEAD_BEEF);

    // Address below base wraps: off = 0xFFFFFFFC -> half-word 0x3FFFE.
    mem_op(1, 0, 32'd1020, 32'd0, 18'h3FFFE, 32'h103F_103E);

    // Non-memory instructions.
    mem_r = 1'b0; mem_w = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wb_en = i[0]; alu = 32'h100 * i + 32'd3; dst = i[3:0]; rm = 32'(i);
      #1;
      chk("nop_freeze", 32'(frz), 32'd0);
      chk("nop_we_n",   32'(s_we_n), 32'd1);
      chk("nop_oe_n",   32'(s_oe_n), 32'd1);
      chk("nop_dq_oe",  32'(s_dq_oe), 32'd0);
      chk("pt_wb",      32'(wb_o), 32'(wb_en));
      chk("pt_mem_r",   32'(mem_r_o), 32'(mem_r));
      chk("pt_alu",     alu_o, alu);
      chk("pt_dest",    32'(dst_o), 32'(dst));
      tick;
    end

    // Reset during the first HIGH cycle of a store.
    mem_w = 1'b1; alu = 32'd1040; rm = 32'hCAFE_F00D;
    tick; tick; tick;
    chk("abort_high_addr", 32'(s_addr), 32'd9);
    rst = 1'b1;
    tick;
    chk("abort_we_n",   32'(s_we_n), 32'd1);
    chk("abort_oe_n",   32'(s_oe_n), 32'd1);
    chk("abort_dq_oe",  32'(s_dq_oe), 32'd0);
    chk("abort_freeze", 32'(frz), 32'd0);
    chk("abort_val",    val, 32'd0);
    rst = 1'b0;
    mem_op(0, 1, 32'd1040, 32'h0BAD_CAFE, 18'd8, 32'd0);
    mem_op(1, 0, 32'd1040, 32'd0,         18'd8, 32'h0BAD_CAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stage_mem_sram.md
Name: stage_mem_sram

Overview:
- MEM stage of the ARM-subset pipeline, directly downstream of the EX stage.
- Consumes the EX results (aluRes as address, exeValRm as store data, memREn/memWEn, wbEn, dest).
- Performs 32-bit loads and stores on an external 16-bit asynchronous SRAM, using two half-word accesses per word.
- Drives freeze back to the pipeline until the access completes, and presents valMem plus pass-through fields to the MEM/WB register.

Parameters:
- BASE_ADDR, 1024: data-memory base; the SRAM offset is aluRes - BASE_ADDR.
- SRAM_ADDR_W, 18: SRAM address width in half-words.
- ACCESS_CYCLES, 2: clock cycles each half-word access holds address, data and control stable (at least 1).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- wbEnIn  in  1  write-back enable from EX
- memREnIn  in  1  load request
- memWEnIn  in  1  store request
- aluRes  in  32  effective address from EX
- exeValRm  in  32  store data from EX
- dest  in  4  destination register from EX
- wbEnOut  out  1  wbEnIn pass-through
- memREnOut  out  1  memREnIn pass-through
- aluResOut  out  32  aluRes pass-through
- destOut  out  4  dest pass-through
- valMem  out  32  registered load data
- freeze  out  1  stall request to all upstream stages and pipeline registers
- sramAddr  out  SRAM_ADDR_W  half-word address
- sramDqOut  out  16  write data
- sramDqIn  in  16  read data
- sramDqOe  out  1  high = this block drives the DQ bus
- sramWeN  out  1  active-low write enable
- sramOeN  out  1  active-low output enable

Behaviour:
- Address mapping:
  - off = aluRes - BASE_ADDR, modulo 2^32.
  - sramAddr = {off[SRAM_ADDR_W:2], half}; half = 0 for bits 15:0, half = 1 for bits 31:16.
  - aluRes[1:0] is ignored. Addresses below BASE_ADDR wrap; no fault is raised.
- FSM states: IDLE, LOW, HIGH, DONE. A cycle counter runs 0..ACCESS_CYCLES-1 inside LOW and HIGH.
- IDLE:
  - If req = memREnIn | memWEnIn, go to LOW with count cleared.
  - Otherwise stay in IDLE.
- LOW: after ACCESS_CYCLES cycles, go to HIGH. On a read, sramDqIn is captured into lowBuf on the last cycle of LOW.
- HIGH: after ACCESS_CYCLES cycles, go to DONE. On a read, valMem <= {sramDqIn, lowBuf} on the last cycle of HIGH.
- DONE: one cycle, then unconditionally back to IDLE. The pipeline advances at the end of this cycle, so the next IDLE sees the next instruction.
- freeze = req & (state != DONE), combinational. It is high from the request cycle until DONE.
  - Total stall per memory instruction = 1 + 2*ACCESS_CYCLES cycles; this is 5 at the default.
  - Non-memory instructions never freeze.
- Read cycles (LOW/HIGH): sramOeN = 0, sramWeN = 1, sramDqOe = 0.
- Write cycles (LOW/HIGH):
  - sramWeN = 0 and sramDqOe = 1.
  - sramDqOut = exeValRm[15:0] in LOW and exeValRm[31:16] in HIGH.
  - sramOeN = 1.
- IDLE/DONE: sramWeN = 1, sramOeN = 1, sramDqOe = 0. sramAddr holds its last value.
- memREnIn and memWEnIn both high: treated as a read; the write is suppressed.
- valMem changes only on completed reads. It holds its value through writes and idle cycles.
- Pass-through outputs (wbEnOut, memREnOut, aluResOut, destOut) are combinational and independent of the FSM.
- Reset, including mid-access:
  - State returns to IDLE and the counter clears.
  - valMem = 0, lowBuf = 0, sramAddr = 0, sramDqOut = 0.
  - sramWeN = 1, sramOeN = 1, sramDqOe = 0.
  - freeze is forced to 0 while rst is high.
  - A partially written word is not completed.

Decomposition:
- Shared package holds:
  - the state enum (IDLE/LOW/HIGH/DONE);
  - BASE_ADDR default;
  - DATA_W = 32 and SRAM_DQ_W = 16.
- One sub-module, sram_controller, owns the FSM, counter, SRAM pins and valMem.
- stage_mem_sram wraps it with the pass-throughs and the freeze output.

Test Plan:
- Reset with memREnIn = 1 held → freeze = 0, sramWeN = 1, sramOeN = 1, valMem = 0 during rst. After release, the FSM leaves IDLE on the first clock.
- Store aluRes = 1024+8, exeValRm = 0xDEADBEEF:
  - freeze high for exactly 5 cycles;
  - sramAddr = 4 with DQ = 0xBEEF for 2 cycles, then sramAddr = 5 with DQ = 0xDEAD for 2 cycles, sramWeN = 0 in all 4 cycles;
  - freeze = 0 in the DONE cycle.
- Load aluRes = 1024+8 with the SRAM model holding the word above → valMem = 0xDEADBEEF in the cycle after HIGH's last cycle. freeze pattern matches the store case.
- Back-to-back load at 1024+0 then store at 1024+4 → two separate 5-cycle freezes with no idle gap. The second request is accepted the cycle after DONE.
- Non-memory instructions (memREnIn = memWEnIn = 0) for 10 cycles → freeze = 0 throughout and SRAM controls inactive. Pass-throughs equal their inputs every cycle.
- rst asserted in the first HIGH cycle of a store → next cycle state is IDLE, sramWeN = 1, sramDqOe = 0, freeze = 0. Rerunning the store rewrites both halves correctly.
